// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory responder for the execute stage. Accepts a load or store
//   request (mem_read/mem_write + funct3), validates size/alignment, runs a
//   single valid/ready bus transaction, and returns the aligned and
//   sign/zero-extended load result for the mem2reg path.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   mem_read, mem_write   load / store request (sampled only in IDLE)
//   funct3                size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata           effective address, LSB-aligned store data
//   stall                 freeze pipeline (combinational)
//   ld_data, done         extended load result, one-cycle completion pulse
//   access_err            one-cycle pulse: misaligned, illegal or timeout
//   bus_req/bus_gnt       request valid / accepted
//   bus_we, bus_addr      direction, word-aligned address
//   bus_be, bus_wdata     byte enables, lane-replicated store data
//   bus_rvalid, bus_rdata read response, full word
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic [XLEN-1:0] ld_data,
   output logic            done,
   output logic            access_err,
   output logic            bus_req,
   input  logic            bus_gnt,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [TO_W-1:0] r_cnt;
   logic [2:0]      r_f3;
   logic [1:0]      r_off;
   logic            r_we, r_err;
   logic [XLEN-1:0] r_addr, r_wdata, r_ld;
   logic [3:0]      r_be;

   logic            w_op, w_illegal, w_misal, w_go, w_bad, w_timeout;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata, w_sh, w_ld;

   // ---------------- request decode (IDLE only) ----------------
   always_comb begin
      w_op      = mem_read | mem_write;
      w_illegal = 1'b0;
      if (mem_read && mem_write)
         w_illegal = 1'b1;
      else if (mem_write && (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010))
         w_illegal = 1'b1;
      else if (mem_read && (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010)
               && (funct3 != 3'b100) && (funct3 != 3'b101))
         w_illegal = 1'b1;
      w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      w_go    = w_op && !w_illegal && !w_misal;
      w_bad   = w_op && (w_illegal || w_misal);
   end

   // Byte enables and lane replication so the store byte/half lands in
   // whichever lane the enables select.
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {(XLEN/8){wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << addr[1:0];
            w_wdata = {(XLEN/16){wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = wdata;
         end
      endcase
   end

   // ---------------- load alignment / extension ----------------
   always_comb begin
      w_sh = bus_rdata >> {r_off, 3'b000};
      case (r_f3)
         3'b000:  w_ld = {{(XLEN-8){w_sh[7]}},   w_sh[7:0]};
         3'b100:  w_ld = {{(XLEN-8){1'b0}},      w_sh[7:0]};
         3'b001:  w_ld = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
         3'b101:  w_ld = {{(XLEN-16){1'b0}},     w_sh[15:0]};
         default: w_ld = bus_rdata;
      endcase
   end

   // Abort fires on the TIMEOUT-th cycle spent in REQ/WAIT without progress.
   assign w_timeout = (r_cnt == TO_W'(TIMEOUT - 1));

   // ---------------- next state ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_go) w_next = S_REQ;
         S_REQ: begin
            if (bus_gnt)        w_next = r_we ? S_DONE : S_WAIT;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_WAIT: begin
            // a grant seen here is meaningless; only rvalid counts
            if (bus_rvalid)     w_next = S_DONE;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_f3    <= '0;
         r_off   <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_ld    <= '0;
      end else begin
         r_state <= w_next;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_bad) begin
                  r_err <= 1'b1;
               end else if (w_go) begin
                  r_we    <= mem_write;
                  r_addr  <= {addr[XLEN-1:2], 2'b00};
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_f3    <= funct3;
                  r_off   <= addr[1:0];
                  r_cnt   <= '0;
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + 1'b1;
               if (!bus_gnt && w_timeout) r_err <= 1'b1;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (bus_rvalid)     r_ld  <= w_ld;
               else if (w_timeout) r_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign stall      = ((r_state == S_IDLE) && w_go) || (r_state == S_REQ) || (r_state == S_WAIT);
   assign bus_req    = (r_state == S_REQ);
   assign done       = (r_state == S_DONE);
   assign access_err = r_err;
   assign bus_we     = r_we;
   assign bus_addr   = r_addr;
   assign bus_be     = r_be;
   assign bus_wdata  = r_wdata;
   assign ld_data    = r_ld;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   localparam int XLEN    = 32;
   localparam int TIMEOUT = 4;
   localparam int TO_W    = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            mem_read, mem_write;
   logic [2:0]      funct3;
   logic [31:0]     addr, wdata;
   logic            stall, done, access_err;
   logic [31:0]     ld_data;
   logic            bus_req, bus_gnt, bus_we, bus_rvalid;
   logic [31:0]     bus_addr, bus_wdata, bus_rdata;
   logic [3:0]      bus_be;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .ld_data(ld_data), .done(done), .access_err(access_err),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] cur_ld;   // bench's view of what ld_data should hold

   task automatic check(input string tag, input string name,
                        input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic m_bad(input logic rd, input logic wr,
                                  input logic [2:0] f3, input logic [31:0] a);
      int sz;
      if (rd && wr) return 1'b1;
      if (wr && f3 > 2) return 1'b1;
      if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
      sz = 1 << f3[1:0];
      return (a % sz) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int sz;
      sz = 1 << f3[1:0];
      return 4'(((1 << sz) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int sz;
      sz = 1 << f3[1:0];
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] rdat);
      longint v;
      int sz;
      sz = 1 << f3[1:0];
      v  = rdat;
      v  = v >> (8 * (a % 4));
      if (sz < 4) begin
         v = v % (64'sd1 <<< (8 * sz));
         if (!f3[2] && v >= (64'sd1 <<< (8 * sz - 1))) v = v - (64'sd1 <<< (8 * sz));
      end
      return 32'(v);
   endfunction

   // ---------------- one access ----------------
   // Called at posedge+1. Grant arrives gdly cycles after REQ entry; a load's
   // rvalid arrives rdly cycles after the first WAIT cycle. With noise set,
   // stray rvalid appears in REQ and a stray gnt accompanies the real rvalid.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int gdly, input int rdly, input logic noise,
                         input logic e_err, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_ld);
      int done_k, stalls, dones, reqs;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      check(tag, "stall_idle", stall, !e_err);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
      if (e_err) begin
         @(negedge clk);
         check(tag, "err_pulse", access_err, 1'b1);
         check(tag, "err_no_req", bus_req, 1'b0);
         check(tag, "err_stall", stall, 1'b0);
         @(posedge clk); #1;
         @(negedge clk);
         check(tag, "err_clear", access_err, 1'b0);
         check(tag, "err_no_req2", bus_req, 1'b0);
         @(posedge clk); #1;
         return;
      end
      done_k = wr ? 2 + gdly : 3 + gdly + rdly;
      stalls = 1; dones = 0; reqs = 0;
      for (int k = 1; k <= done_k; k++) begin
         bus_gnt    = (k == 1 + gdly);
         bus_rvalid = rd && (k == 2 + gdly + rdly);
         bus_rdata  = $urandom;
         if (bus_rvalid) begin
            bus_rdata = rdat;
            if (noise) bus_gnt = 1'($urandom_range(0, 1));
         end else if (noise && k <= 1 + gdly) begin
            bus_rvalid = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (stall)   stalls++;
         if (done)    dones++;
         if (bus_req) reqs++;
         if (k <= 1 + gdly) begin
            check(tag, "bus_we", bus_we, wr);
            check(tag, "bus_addr", bus_addr, {a[31:2], 2'b00});
            check(tag, "bus_be", bus_be, e_be);
            if (wr) check(tag, "bus_wdata", bus_wdata, e_wd);
         end
         if (k == done_k) begin
            check(tag, "done", done, 1'b1);
            check(tag, "ld_data", ld_data, e_ld);
            check(tag, "stall_done", stall, 1'b0);
            check(tag, "no_err", access_err, 1'b0);
         end
         @(posedge clk); #1;
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      check(tag, "stall_cycles", stalls, done_k);
      check(tag, "done_count", dones, 1);
      check(tag, "req_cycles", reqs, 1 + gdly);
      cur_ld = e_ld;
   endtask

   typedef struct {
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, wd, rdat;
      int          gdly, rdly;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wdat, ld;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic        rd, wr, bad;
      logic [2:0]  f3;
      logic [31:0] a, wd, rdat, eld;
      int          gd, rdl, r;

      tbl[0]  = '{1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        2, 0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'h203, 32'h0,        32'h80FF0000, 0, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
      tbl[2]  = '{1'b1, 1'b0, 3'd5, 32'h202, 32'h0,        32'h80011234, 1, 0, 1'b0, 4'b1100, 32'h0,        32'h00008001};
      tbl[3]  = '{1'b0, 1'b1, 3'd0, 32'h101, 32'h000000AB, 32'h0,        0, 0, 1'b0, 4'b0010, 32'hABABABAB, 32'h00008001};
      tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h102, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[5]  = '{1'b1, 1'b1, 3'd2, 32'h100, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[6]  = '{1'b1, 1'b0, 3'd1, 32'h206, 32'h0,        32'h7FFF8000, 0, 1, 1'b0, 4'b1100, 32'h0,        32'h00007FFF};
      tbl[7]  = '{1'b1, 1'b0, 3'd4, 32'h201, 32'h0,        32'h0000F100, 0, 0, 1'b0, 4'b0010, 32'h0,        32'h000000F1};
      tbl[8]  = '{1'b0, 1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0,        3, 0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h000000F1};
      tbl[9]  = '{1'b0, 1'b1, 3'd2, 32'h101, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[10] = '{1'b0, 1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[11] = '{1'b1, 1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[12] = '{1'b1, 1'b0, 3'd1, 32'h201, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[13] = '{1'b1, 1'b0, 3'd2, 32'h300, 32'h0,        32'hCAFEF00D, 1, 1, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D};

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
      addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      cur_ld = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset", "stall", stall, 1'b0);
      check("reset", "done", done, 1'b0);
      check("reset", "access_err", access_err, 1'b0);
      check("reset", "bus_req", bus_req, 1'b0);
      check("reset", "bus_we", bus_we, 1'b0);
      check("reset", "bus_addr", bus_addr, 32'h0);
      check("reset", "bus_be", bus_be, 4'h0);
      check("reset", "bus_wdata", bus_wdata, 32'h0);
      check("reset", "ld_data", ld_data, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // -------- directed table --------
      foreach (tbl[i])
         access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a,
                tbl[i].wd, tbl[i].rdat, tbl[i].gdly, tbl[i].rdly, 1'b0,
                tbl[i].err, tbl[i].be, tbl[i].wdat, tbl[i].ld);

      // -------- timeout in REQ: LW, grant never comes --------
      mem_read = 1'b1; funct3 = 3'd2; addr = 32'h400;
      @(posedge clk); #1;
      mem_read = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("to_req", "bus_req", bus_req, 1'b1);
         check("to_req", "stall", stall, 1'b1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("to_req", "err", access_err, 1'b1);
      check("to_req", "bus_req_off", bus_req, 1'b0);
      check("to_req", "no_done", done, 1'b0);
      check("to_req", "stall_off", stall, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check("to_req", "err_clear", access_err, 1'b0);
      check("to_req", "no_done2", done, 1'b0);
      @(posedge clk); #1;

      // -------- timeout in WAIT: grant, rvalid never comes --------
      mem_read = 1'b1; funct3 = 3'd2; addr = 32'h404;
      @(posedge clk); #1;
      mem_read = 1'b0; bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         check("to_wait", "stall", stall, 1'b1);
         check("to_wait", "err_early", access_err, 1'b0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("to_wait", "err", access_err, 1'b1);
      check("to_wait", "no_done", done, 1'b0);
      check("to_wait", "ld_keep", ld_data, cur_ld);
      @(posedge clk); #1;

      // -------- reset while in WAIT, late rvalid ignored --------
      mem_read = 1'b1; funct3 = 3'd0; addr = 32'h500;
      @(posedge clk); #1;
      mem_read = 1'b0; bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rst_wait", "stall_before", stall, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h000000FF;
      @(negedge clk);
      check("rst_wait", "bus_req", bus_req, 1'b0);
      check("rst_wait", "stall", stall, 1'b0);
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      @(negedge clk);
      check("rst_wait", "no_done", done, 1'b0);
      check("rst_wait", "ld_data", ld_data, 32'h0);
      cur_ld = 32'h0;
      @(posedge clk); #1;

      // -------- randomized against the model --------
      for (int n = 0; n < 200; n++) begin
         r  = $urandom_range(0, 9);
         rd = (r <= 4) || (r == 9);
         wr = (r >= 5);
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
              (wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         wd   = $urandom;
         rdat = $urandom;
         if (wr && !rd) begin
            gd = $urandom_range(0, 3); rdl = 0;
         end else begin
            gd = $urandom_range(0, 2); rdl = $urandom_range(0, 2 - gd);
         end
         bad = m_bad(rd, wr, f3, a);
         eld = (rd && !bad) ? m_ld(f3, a, rdat) : cur_ld;
         access($sformatf("rnd%0d", n), rd, wr, f3, a, wd, rdat, gd, rdl, 1'b1,
                bad, bad ? 4'h0 : m_be(f3, a), bad ? 32'h0 : m_wd(f3, wd), eld);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
